// File: rtl/nand_vector_checker.sv
// nand_vector_checker
//   Drives every {a,b} combination into a WIDTH-bit bitwise NAND gate. It
//   holds each vector for a settle window, then compares the gate response
//   against ~(a & b). It counts mismatches, records the first failing
//   vector and reports pass/fail at the end of the sweep.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          request a full sweep (honoured in IDLE or DONE only)
//   a_out, b_out   registered stimulus to the gate inputs
//   c_in           gate response
//   busy           sweep in progress
//   done           sweep finished, results stable
//   pass           valid with done; 1 when no vector mismatched
//   err_count      number of mismatching vectors in the last sweep
//   fail_valid     at least one mismatch recorded
//   first_fail_vec {a,b} index of the first mismatch
//
// state  | meaning
// IDLE   | waiting for start after reset
// SETTLE | current vector applied, waiting for the gate output to settle
// CHECK  | one cycle: sample c_in, score it, advance or finish
// DONE   | sweep complete, results held until next start
module nand_vector_checker #(
  parameter int WIDTH         = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  input  logic [WIDTH-1:0]     c_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic                 fail_valid,
  output logic [2*WIDTH-1:0]   first_fail_vec
);

  localparam int VW = 2 * WIDTH;
  // A zero settle window would make CHECK follow itself; treat it as one cycle.
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [VW-1:0]     r_vec;
  logic [7:0]        r_settle_cnt;
  logic [VW:0]       r_err_count;
  logic              r_fail_valid;
  logic [VW-1:0]     r_first_fail;
  logic              r_pass;

  logic [WIDTH-1:0]  w_expected;
  logic              w_mismatch;
  logic              w_last_vec;
  logic              w_settle_done;
  logic              w_start_ok;

  assign a_out = r_vec[VW-1:WIDTH];
  assign b_out = r_vec[WIDTH-1:0];

  // Expected value is derived from the registered stimulus the gate actually sees.
  assign w_expected    = ~(a_out & b_out);
  assign w_mismatch    = (c_in != w_expected);
  assign w_last_vec    = (r_vec == {VW{1'b1}});
  assign w_settle_done = (r_settle_cnt == SETTLE_LAST);
  assign w_start_ok    = start && ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (w_start_ok) w_state_nxt = SETTLE;
      SETTLE:     if (w_settle_done) w_state_nxt = CHECK;
      CHECK:      w_state_nxt = w_last_vec ? DONE : SETTLE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec        <= '0;
      r_settle_cnt <= '0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_vec        <= '0;
            r_settle_cnt <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
            r_pass       <= 1'b0;
          end
        end
        SETTLE: begin
          r_settle_cnt <= r_settle_cnt + 8'd1;
        end
        CHECK: begin
          if (w_mismatch) begin
            r_err_count <= r_err_count + (VW+1)'(1);
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_first_fail <= r_vec;
            end
          end
          if (w_last_vec) begin
            // Include this cycle's result, which is not yet in r_err_count.
            r_pass <= (r_err_count == '0) && !w_mismatch;
          end else begin
            r_vec        <= r_vec + VW'(1);
            r_settle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy           = (r_state == SETTLE) || (r_state == CHECK);
  assign done           = (r_state == DONE);
  assign pass           = r_pass;
  assign err_count      = r_err_count;
  assign fail_valid     = r_fail_valid;
  assign first_fail_vec = r_first_fail;

endmodule
